// File: rtl/neuron_sequencer.sv
// Sequences one neuron MAC evaluation: clear, N accumulate taps, activate and capture.
// Latency N+3 cycles from accepted start to result_valid, plus one per stall cycle.
// stall pauses accumulation only; start is ignored while busy.
module neuron_sequencer #(
    parameter int N  = 10,
    parameter int DW = 8,
    parameter int OW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hidden_in,
    input  logic          stall,
    input  logic [DW-1:0] result_in,
    output logic [OW-1:0] offset,
    output logic          acc_clr,
    output logic          acc_ld,
    output logic          act_ready,
    output logic          hidden,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result_out,
    output logic          result_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        ACC  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [OW-1:0] LAST_TAP = OW'(N - 1);

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            offset       <= '0;
            hidden       <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= CLR;
                        hidden       <= hidden_in;
                        offset       <= '0;
                        result_valid <= 1'b0;
                    end
                end
                CLR: state <= ACC;
                ACC: begin
                    // Offset returns to 0 on the last tap so it never visits unused codes.
                    if (!stall) begin
                        if (offset == LAST_TAP) begin
                            state  <= FIN;
                            offset <= '0;
                        end else begin
                            offset <= offset + 1'b1;
                        end
                    end
                end
                FIN: begin
                    result_out   <= result_in;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign acc_clr   = (state == CLR);
    assign acc_ld    = (state == ACC) && !stall;
    assign act_ready = (state == FIN);
    assign done      = (state == FIN);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomized bench for neuron_sequencer (N=10 and N=1 instances sharing stimulus) against a tap-counting model.
module tb_neuron_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hidden_in = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] result_in = 8'h00;

    logic [3:0] off0;
    logic       clr0, ld0, rdy0, hid0, bsy0, dn0, vld0;
    logic [7:0] res0;
    logic [0:0] off1;
    logic       clr1, ld1, rdy1, hid1, bsy1, dn1, vld1;
    logic [7:0] res1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    neuron_sequencer #(.N(10), .DW(8)) dut0 (
        .clk(clk), .rst(rst), .start(start), .hidden_in(hidden_in), .stall(stall),
        .result_in(result_in), .offset(off0), .acc_clr(clr0), .acc_ld(ld0),
        .act_ready(rdy0), .hidden(hid0), .busy(bsy0), .done(dn0),
        .result_out(res0), .result_valid(vld0)
    );

    neuron_sequencer #(.N(1), .DW(8)) dut1 (
        .clk(clk), .rst(rst), .start(start), .hidden_in(hidden_in), .stall(stall),
        .result_in(result_in), .offset(off1), .acc_clr(clr1), .acc_ld(ld1),
        .act_ready(rdy1), .hidden(hid1), .busy(bsy1), .done(dn1),
        .result_out(res1), .result_valid(vld1)
    );

    // Model: an evaluation is "clear, then N taps, then finish", tracked as taps completed.
    int         nn[2] = '{10, 1};
    bit         m_in_eval[2];
    bit         m_cleared[2];
    int         m_taps[2];
    bit         m_hidden[2];
    logic [7:0] m_res[2];
    bit         m_valid[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_dut(input int d, input logic [31:0] off, input logic clr, input logic ld,
                               input logic rdy, input logic hid, input logic bsy, input logic dn,
                               input logic [7:0] res, input logic vld);
        bit tapping;
        bit finishing;
        tapping   = m_in_eval[d] && m_cleared[d] && (m_taps[d] < nn[d]);
        finishing = m_in_eval[d] && m_cleared[d] && (m_taps[d] == nn[d]);
        check($sformatf("d%0d_offset", d), off, tapping ? 32'(m_taps[d]) : 32'd0);
        check($sformatf("d%0d_acc_clr", d), 32'(clr), 32'(m_in_eval[d] && !m_cleared[d]));
        check($sformatf("d%0d_acc_ld", d), 32'(ld), 32'(tapping && !stall));
        check($sformatf("d%0d_act_ready", d), 32'(rdy), 32'(finishing));
        check($sformatf("d%0d_done", d), 32'(dn), 32'(finishing));
        check($sformatf("d%0d_busy", d), 32'(bsy), 32'(m_in_eval[d]));
        check($sformatf("d%0d_hidden", d), 32'(hid), 32'(m_hidden[d]));
        check($sformatf("d%0d_result_out", d), 32'(res), 32'(m_res[d]));
        check($sformatf("d%0d_result_valid", d), 32'(vld), 32'(m_valid[d]));
    endtask

    task automatic model_update(input int d);
        if (rst) begin
            m_in_eval[d] = 0; m_cleared[d] = 0; m_taps[d] = 0;
            m_hidden[d] = 0; m_res[d] = 8'h00; m_valid[d] = 0;
        end else if (!m_in_eval[d]) begin
            if (start) begin
                m_in_eval[d] = 1; m_cleared[d] = 0; m_taps[d] = 0;
                m_hidden[d] = hidden_in; m_valid[d] = 0;
            end
        end else if (!m_cleared[d]) begin
            m_cleared[d] = 1;
        end else if (m_taps[d] < nn[d]) begin
            if (!stall) m_taps[d]++;
        end else begin
            m_res[d] = result_in;
            m_valid[d] = 1;
            m_in_eval[d] = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check just after, advance the model at posedge.
    task automatic step(input logic s, input logic h, input logic sl, input logic r, input logic [7:0] ri);
        @(negedge clk);
        start = s; hidden_in = h; stall = sl; rst = r; result_in = ri;
        #1;
        compare_dut(0, 32'(off0), clr0, ld0, rdy0, hid0, bsy0, dn0, res0, vld0);
        compare_dut(1, 32'(off1), clr1, ld1, rdy1, hid1, bsy1, dn1, res1, vld1);
        @(posedge clk);
        model_update(0);
        model_update(1);
    endtask

    initial begin
        int sc;
        int guard;
        for (int d = 0; d < 2; d++) begin
            m_in_eval[d] = 0; m_cleared[d] = 0; m_taps[d] = 0;
            m_hidden[d] = 0; m_res[d] = 8'h00; m_valid[d] = 0;
        end
        repeat (2) @(posedge clk);

        // Reset state, then a plain evaluation with hidden_in=1 and result 5A.
        step(0, 0, 0, 1, 8'h00);
        step(1, 1, 0, 0, 8'h5A);
        repeat (15) step(0, 0, 0, 0, 8'h5A);

        // Stall three cycles while the N=10 instance sits at offset 4.
        step(1, 0, 0, 0, 8'h33);
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            logic sl;
            sl = m_in_eval[0] && m_cleared[0] && (m_taps[0] == 4) && (sc < 3);
            if (sl) sc++;
            step(0, 1, sl, 0, 8'h33);
        end

        // start held high: back-to-back issue, hidden_in toggling while busy.
        for (int i = 0; i < 45; i++) step(1, 1'(i % 2), 0, 0, 8'(i * 7));

        // Reset mid-accumulate at offset 6, then a clean evaluation.
        step(1, 1, 0, 0, 8'hC3);
        guard = 0;
        while (!(m_in_eval[0] && m_cleared[0] && m_taps[0] == 6) && guard < 30) begin
            step(0, 0, 0, 0, 8'hC3);
            guard++;
        end
        check("reach_offset6", 32'(guard < 30), 32'd1);
        step(0, 0, 0, 1, 8'hC3);
        step(1, 0, 1, 0, 8'h11);
        repeat (15) step(0, 0, 0, 0, 8'h11);

        // Randomized traffic, including rare resets and stalls anywhere.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 99) == 0), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
- FSM controller that drives one neuron MAC datapath through a full evaluation.
- Per evaluation: clear the accumulator, step the input/weight select offset through all N taps with accumulate-enable, then assert the activation-ready strobe and capture the activated result.
- Sits between the layer-level controller (start/done handshake) and the neuron datapath (offset, ld, rst, ready, hidden controls).

Parameters:
- N, 10, number of input/weight taps per neuron; legal range ≥1.
- DW, 8, width of the activated result word.
- OW, (N>1 ? $clog2(N) : 1), offset width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request one neuron evaluation; sampled only in IDLE.
- hidden_in  input  1  layer type for this evaluation; sampled together with an accepted start.
- stall  input  1  pause accumulation (upstream operands not valid).
- result_in  input  DW  activated output from the datapath.
- offset  output  OW  tap select to the datapath.
- acc_clr  output  1  accumulator synchronous clear, to datapath rst.
- acc_ld  output  1  accumulator load enable, to datapath ld.
- act_ready  output  1  activation enable, to datapath ready.
- hidden  output  1  latched layer type, to datapath hidden.
- busy  output  1  high in CLR, ACC and FIN.
- done  output  1  one-cycle pulse, coincident with act_ready.
- result_out  output  DW  captured result.
- result_valid  output  1  result_out holds a result from the most recent evaluation.

Behaviour:
- States: IDLE, CLR, ACC, FIN. State, offset, hidden, result_out and result_valid are registered.
- Outputs acc_clr, acc_ld, act_ready, done and busy are decoded combinationally from state (Moore), plus stall for acc_ld.
- Reset (rst=1 at an edge), from any state including mid-evaluation:
  - state=IDLE, offset=0, hidden=0, result_out=0, result_valid=0.
  - All decoded outputs are 0.
- IDLE:
  - start=1 → next state CLR; hidden<=hidden_in; offset<=0; result_valid<=0.
  - start=0 → remain in IDLE.
- CLR: acc_clr=1 for exactly one cycle → ACC.
- ACC:
  - stall=0: acc_ld=1. If offset==N-1 → FIN with offset<=0; else offset<=offset+1.
  - stall=1: acc_ld=0, offset holds, remain in ACC.
- FIN:
  - act_ready=1, done=1, for one cycle.
  - result_out<=result_in at the end of the cycle; result_valid<=1.
  - Next state IDLE.
- Latency: with start accepted at edge E0 and no stalls:
  - CLR is the cycle after E0.
  - ACC lasts N cycles, offset 0..N-1.
  - FIN is cycle N+2 after E0.
  - result_valid is high from cycle N+3.
  - Each stall cycle adds one cycle.
- Back-to-back: start is honoured in the first IDLE cycle after FIN. Minimum issue interval is N+3 cycles.
- start while busy is ignored: no queuing, no effect on hidden.
- stall in IDLE, CLR or FIN is ignored.
- hidden holds its latched value through IDLE until the next accepted start.
- result_out holds until the next FIN capture. result_valid drops on the cycle after the next accepted start.
- N=1: ACC lasts one unstalled cycle with offset=0, then FIN.
- offset never exceeds N-1. For non-power-of-two N there is no wrap through unused codes.

Test Plan:
- Reset, then N=10, start pulse with hidden_in=1 → CLR 1 cycle; acc_ld=1 for 10 cycles with offset 0..9; FIN with act_ready=done=1 at cycle 12; hidden=1 throughout; result_in=8'h5A captured, result_valid=1 at cycle 13.
- Stall=1 for 3 cycles while offset=4 → offset holds at 4 and acc_ld=0 for those cycles; FIN arrives at cycle 15 (not 12); exactly 10 acc_ld cycles in total.
- start held high continuously → evaluations issue every 13 cycles; start pulses during busy are ignored; hidden_in toggled while busy does not change hidden.
- rst asserted while offset=6 in ACC → next cycle state IDLE, offset=0, busy=0, result_valid=0, result_out=0; a new start runs a clean full sequence.
- N=1 instance → CLR, one ACC cycle at offset 0, FIN; done at cycle 3; stall during CLR has no effect.
- After a completed run, a new start with hidden_in=0 → result_valid drops the cycle after start; previous result_out is held until the new FIN overwrites it.
